mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single p18240 memory port between two requesters: the CPU datapath
//  (MAR/MDR path) and the debug loader. Each side sees a simple req/ack handshake.
//  The block arbitrates between them and sequences one memory access at a time.
//  It drives active-low read/write strobes, addr and write data, then returns read data.
// PARAMETERS
//  ADDR_W       16  address width
//  DATA_W       16  data width
//  WAIT_CYCLES  1   cycles strobe held low per access; legal range 1..15
// PORTS
//  clock      in   1       single system clock, rising edge
//  reset_L    in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU request; level, held until cpu_ack
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
//  cpu_ack    out  1       one-cycle completion pulse
//  dbg_req / dbg_we / dbg_addr / dbg_wdata / dbg_rdata / dbg_ack: same as cpu_* for the debug loader
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  mem_re_L   out  1       active-low read strobe
//  mem_we_L   out  1       active-low write strobe
//  busy       out  1       1 when state != IDLE
//  owner      out  1       0=CPU, 1=DBG; current or last grantee
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, including mid-access):
//    state=IDLE; mem_re_L=mem_we_L=1; mem_addr, mem_wdata, *_rdata = 0;
//    *_ack=0; busy=0; owner=1, so the CPU wins the first tie.
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE:
//    No request: stay in IDLE.
//    Otherwise, at the clock edge: pick the winner, latch its we/addr/wdata into
//    mem_*, set owner, load cnt=WAIT_CYCLES, go to ACCESS.
//    Strobes are registered and go low in the first ACCESS cycle.
//  ACCESS:
//    Exactly one strobe is low: mem_re_L if !we, mem_we_L if we.
//    cnt decrements each cycle.
//    On the edge where cnt==1: if read, capture mem_rdata into the owner's rdata
//    register; go to DONE.
//  DONE:
//    Strobes high. Owner's ack=1 for exactly this cycle. Go to IDLE.
//  Latency: req sampled at edge k -> ack high in cycle k+WAIT_CYCLES+1.
//    The next access starts no earlier than one IDLE cycle later.
//  Arbitration (round-robin):
//    If both requests are present in IDLE, grant the requester != owner.
//    A single requester always wins.
//  Address/data are latched at grant. Requester input changes after grant are ignored.
//  Dropping req after grant does not abort: the access completes and ack still pulses.
//  Requester must deassert req in the DONE cycle or the cycle after.
//    If req is still high in IDLE it is treated as a new request.
//  The non-granted requester's rdata holds its previous value; its ack stays 0.
//  The two acks are never high in the same cycle.
//  The two strobes are never low simultaneously.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: strict priority; CPU always wins ties and DBG
//    waits for an IDLE cycle with cpu_req=0. owner still reports the grantee.
//  MEM_ARB_FIXED_PRIO_EN undefined: round-robin exactly as described above.
// TESTING
//  1. Reset, WAIT_CYCLES=1, CPU read 16'h2000 with mem_rdata=16'hBEEF:
//     mem_re_L low 1 cycle; cpu_ack high 2 cycles after req; cpu_rdata=16'hBEEF.
//  2. DBG write addr 16'h0040 data 16'h1234:
//     mem_we_L low 1 cycle with mem_addr=0040, mem_wdata=1234;
//     dbg_ack pulses; mem_re_L stays 1.
//  3. cpu_req and dbg_req both held high from reset, 4 accesses:
//     grants CPU, DBG, CPU, DBG (round-robin).
//     With MEM_ARB_FIXED_PRIO_EN: CPU, CPU, CPU, CPU.
//  4. WAIT_CYCLES=3, CPU read; change cpu_addr and drop cpu_req 1 cycle after grant:
//     mem_addr unchanged, strobe low 3 cycles, cpu_ack still pulses once.
//  5. Assert reset_L=0 in the 2nd ACCESS cycle of a write:
//     mem_we_L=1 and busy=0 immediately (same cycle); after release a CPU request
//     is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes and the memory port shared by mem_port_arbiter.
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata stable; the arbiter samples them
// at grant, and *_ack pulses for one cycle at completion with *_rdata valid while ack is high.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_re_L;
  logic              mem_we_L;

  logic              busy;
  logic              owner;
  logic [1:0]        arb_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_re_L, mem_we_L,
    input  mem_rdata,
    output busy, owner, arb_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_re_L, mem_we_L,
    output mem_rdata,
    input  busy, owner, arb_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the debug loader, one access at a time.
// Define MEM_ARB_FIXED_PRIO_EN for strict CPU priority; otherwise ties alternate round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset_L,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we, w_we_nxt;
  logic              r_owner, w_owner_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_re_l, w_re_l_nxt;
  logic              r_we_l, w_we_l_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_dbg_rdata, w_dbg_rdata_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_dbg_ack, w_dbg_ack_nxt;
  logic              w_any_req;
  logic              w_grant_dbg;

  assign w_any_req = bus.cpu_req | bus.dbg_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_grant_dbg = ~bus.cpu_req;
`else
  // On a tie the side that did not own the port last time wins.
  assign w_grant_dbg = (bus.cpu_req & bus.dbg_req) ? ~r_owner : bus.dbg_req;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_owner_nxt     = r_owner;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_re_l_nxt      = r_re_l;
    w_we_l_nxt      = r_we_l;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dbg_rdata_nxt = r_dbg_rdata;
    w_cpu_ack_nxt   = 1'b0;
    w_dbg_ack_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_owner_nxt     = w_grant_dbg;
          w_we_nxt        = w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
          w_mem_addr_nxt  = w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
          w_mem_wdata_nxt = w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          w_cnt_nxt       = LP_WAIT;
          w_re_l_nxt      = w_we_nxt;
          w_we_l_nxt      = ~w_we_nxt;
          w_state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_re_l_nxt = 1'b1;
          w_we_l_nxt = 1'b1;
          if (!r_we) begin
            if (r_owner) w_dbg_rdata_nxt = bus.mem_rdata;
            else         w_cpu_rdata_nxt = bus.mem_rdata;
          end
          // Ack is registered so it is high exactly for the DONE cycle.
          if (r_owner) w_dbg_ack_nxt = 1'b1;
          else         w_cpu_ack_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_re_l_nxt  = 1'b1;
        w_we_l_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_owner     <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_re_l      <= 1'b1;
      r_we_l      <= 1'b1;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_owner     <= w_owner_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_re_l      <= w_re_l_nxt;
      r_we_l      <= w_we_l_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dbg_rdata <= w_dbg_rdata_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_dbg_ack   <= w_dbg_ack_nxt;
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re_L  = r_re_l;
  assign bus.mem_we_L  = r_we_l;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dbg_rdata = r_dbg_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.dbg_ack   = r_dbg_ack;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.owner     = r_owner;
  assign bus.arb_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_mem_port_arbiter;

  logic clock;
  logic reset_L;
  logic rst3_n;
  int   n_total;
  int   n_bad;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus1)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clock   (clock),
    .reset_L (rst3_n),
    .bus     (bus3)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
    bus1.mem_rdata = '0;
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.dbg_req = 0; bus3.dbg_we = 0; bus3.dbg_addr = '0; bus3.dbg_wdata = '0;
    bus3.mem_rdata = '0;
  endtask

  logic [3:0]  exp_own;
  logic [15:0] exp_dbg_rdata;

  initial begin
    n_total = 0;
    n_bad   = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_own       = 4'b0000;
    exp_dbg_rdata = 16'h0000;
`else
    exp_own       = 4'b1010;
    exp_dbg_rdata = 16'h1111;
`endif
    idle_inputs();
    reset_L = 1'b0;
    rst3_n  = 1'b0;
    repeat (3) step();

    // reset values
    check("rst_busy",   32'(bus1.busy), 32'h0);
    check("rst_re_L",   32'(bus1.mem_re_L), 32'h1);
    check("rst_we_L",   32'(bus1.mem_we_L), 32'h1);
    check("rst_addr",   32'(bus1.mem_addr), 32'h0);
    check("rst_wdata",  32'(bus1.mem_wdata), 32'h0);
    check("rst_cpu_rd", 32'(bus1.cpu_rdata), 32'h0);
    check("rst_dbg_rd", 32'(bus1.dbg_rdata), 32'h0);
    check("rst_acks",   32'({bus1.cpu_ack, bus1.dbg_ack}), 32'h0);
    check("rst_owner",  32'(bus1.owner), 32'h1);
    reset_L = 1'b1;
    rst3_n  = 1'b1;

    // test 1: CPU read, WAIT_CYCLES=1
    bus1.mem_rdata = 16'hBEEF;
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h2000;
    step();
    check("t1_re_low",   32'(bus1.mem_re_L), 32'h0);
    check("t1_we_high",  32'(bus1.mem_we_L), 32'h1);
    check("t1_addr",     32'(bus1.mem_addr), 32'h2000);
    check("t1_owner",    32'(bus1.owner), 32'h0);
    check("t1_busy",     32'(bus1.busy), 32'h1);
    check("t1_ack_early",32'(bus1.cpu_ack), 32'h0);
    step();
    check("t1_ack",      32'(bus1.cpu_ack), 32'h1);
    check("t1_dbg_ack",  32'(bus1.dbg_ack), 32'h0);
    check("t1_rdata",    32'(bus1.cpu_rdata), 32'hBEEF);
    check("t1_re_rel",   32'(bus1.mem_re_L), 32'h1);
    bus1.cpu_req = 0;
    step();
    check("t1_ack_drop", 32'(bus1.cpu_ack), 32'h0);
    check("t1_idle",     32'(bus1.busy), 32'h0);

    // test 2: DBG write
    bus1.dbg_req = 1; bus1.dbg_we = 1; bus1.dbg_addr = 16'h0040; bus1.dbg_wdata = 16'h1234;
    step();
    check("t2_we_low",   32'(bus1.mem_we_L), 32'h0);
    check("t2_re_high",  32'(bus1.mem_re_L), 32'h1);
    check("t2_addr",     32'(bus1.mem_addr), 32'h0040);
    check("t2_wdata",    32'(bus1.mem_wdata), 32'h1234);
    check("t2_owner",    32'(bus1.owner), 32'h1);
    step();
    check("t2_dbg_ack",  32'(bus1.dbg_ack), 32'h1);
    check("t2_cpu_ack",  32'(bus1.cpu_ack), 32'h0);
    check("t2_we_rel",   32'(bus1.mem_we_L), 32'h1);
    check("t2_cpu_hold", 32'(bus1.cpu_rdata), 32'hBEEF);
    bus1.dbg_req = 0; bus1.dbg_we = 0;
    step();
    check("t2_idle",     32'(bus1.busy), 32'h0);

    // test 3: both requesting from reset
    reset_L = 1'b0;
    bus1.mem_rdata = 16'h1111;
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h0010;
    bus1.dbg_req = 1; bus1.dbg_we = 0; bus1.dbg_addr = 16'h0020;
    step();
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 20 && !bus1.busy; c++) step();
      check("t3_busy",  32'(bus1.busy), 32'h1);
      check("t3_owner", 32'(bus1.owner), 32'(exp_own[i]));
      check("t3_addr",  32'(bus1.mem_addr), exp_own[i] ? 32'h0020 : 32'h0010);
      for (int c = 0; c < 20 && !(bus1.cpu_ack || bus1.dbg_ack); c++) step();
      check("t3_cpu_ack", 32'(bus1.cpu_ack), 32'(!exp_own[i]));
      check("t3_dbg_ack", 32'(bus1.dbg_ack), 32'(exp_own[i]));
      step();
      check("t3_gap", 32'(bus1.busy), 32'h0);
      if (i == 3) begin
        bus1.cpu_req = 0;
        bus1.dbg_req = 0;
      end
    end
    step();
    check("t3_stop",      32'(bus1.busy), 32'h0);
    check("t3_dbg_rdata", 32'(bus1.dbg_rdata), 32'(exp_dbg_rdata));
    check("t3_cpu_rdata", 32'(bus1.cpu_rdata), 32'h1111);

    // test 4: WAIT_CYCLES=3, inputs change after grant
    bus3.mem_rdata = 16'hCAFE;
    bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 16'h0100;
    step();
    check("t4_re_c1",  32'(bus3.mem_re_L), 32'h0);
    check("t4_addr_c1",32'(bus3.mem_addr), 32'h0100);
    bus3.cpu_addr = 16'h0F0F;
    bus3.cpu_req  = 0;
    step();
    check("t4_re_c2",  32'(bus3.mem_re_L), 32'h0);
    check("t4_addr_c2",32'(bus3.mem_addr), 32'h0100);
    check("t4_ack_c2", 32'(bus3.cpu_ack), 32'h0);
    step();
    check("t4_re_c3",  32'(bus3.mem_re_L), 32'h0);
    check("t4_ack_c3", 32'(bus3.cpu_ack), 32'h0);
    step();
    check("t4_ack",    32'(bus3.cpu_ack), 32'h1);
    check("t4_rdata",  32'(bus3.cpu_rdata), 32'hCAFE);
    check("t4_re_rel", 32'(bus3.mem_re_L), 32'h1);
    step();
    check("t4_ack_once", 32'(bus3.cpu_ack), 32'h0);
    check("t4_idle",     32'(bus3.busy), 32'h0);
    step();
    check("t4_no_retry", 32'(bus3.busy), 32'h0);

    // test 5: reset in the 2nd ACCESS cycle of a CPU write
    bus3.cpu_req = 1; bus3.cpu_we = 1; bus3.cpu_addr = 16'h0200; bus3.cpu_wdata = 16'h5555;
    step();
    check("t5_we_c1",  32'(bus3.mem_we_L), 32'h0);
    step();
    check("t5_we_c2",  32'(bus3.mem_we_L), 32'h0);
    check("t5_wdata",  32'(bus3.mem_wdata), 32'h5555);
    check("t5_owner_pre", 32'(bus3.owner), 32'h0);
    #2;
    rst3_n = 1'b0;
    bus3.cpu_we  = 0;
    bus3.dbg_req = 1; bus3.dbg_we = 0; bus3.dbg_addr = 16'h0300;
    #1;
    check("t5_rst_we_L",  32'(bus3.mem_we_L), 32'h1);
    check("t5_rst_busy",  32'(bus3.busy), 32'h0);
    check("t5_rst_owner", 32'(bus3.owner), 32'h1);
    check("t5_rst_addr",  32'(bus3.mem_addr), 32'h0);
    @(posedge clock);
    #3;
    rst3_n = 1'b1;
    @(posedge clock);
    #1;
    check("t5_grant_busy",  32'(bus3.busy), 32'h1);
    check("t5_grant_owner", 32'(bus3.owner), 32'h0);
    check("t5_grant_addr",  32'(bus3.mem_addr), 32'h0200);
    check("t5_grant_re",    32'(bus3.mem_re_L), 32'h0);
    bus3.cpu_req = 0;
    bus3.dbg_req = 0;
    repeat (6) step();
    check("t5_settle", 32'(bus3.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
